eth_mdio_responder: RTL and testbench

PHY-side Clause-22 MDIO management responder, the target end of the SMI link driven by `eth_smi`. It decodes MDC/MDIO frames, forwards matching register writes, and answers matching register reads over a simple register-bank port. It sits in the PHY emulation/loopback path and in the system bench, in the `clk_mac` domain, so the existing management initiator can be run against it in place of the external PHY.

---
 rtl/eth_mdio_pkg.sv | 30 +++
 rtl/eth_mdio_responder_if.sv | 26 ++
 rtl/eth_mdio_sync.sv | 35 +++
 rtl/eth_mdio_responder.sv | 227 ++++++++++++++++++++++
 tb/tb_eth_mdio_responder.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/eth_mdio_pkg.sv
// Shared constants, field widths and FSM encoding for the Clause-22 MDIO responder.
package eth_mdio_pkg;

    localparam int unsigned MDIO_ADDR_W = 5;
    localparam int unsigned MDIO_DATA_W = 16;
    localparam int unsigned MDIO_TA_W   = 2;
    localparam int unsigned MDIO_OP_W   = 2;
    localparam int unsigned MDIO_CNT_W  = 5;
    localparam int unsigned MDIO_PRE_W  = 6;

    localparam logic [1:0] MDIO_ST    = 2'b01;
    localparam logic [1:0] MDIO_OP_RD = 2'b10;
    localparam logic [1:0] MDIO_OP_WR = 2'b01;

    typedef enum logic [2:0] {
        S_PRE,
        S_ST,
        S_OP,
        S_PHYAD,
        S_REGAD,
        S_TA,
        S_DATA
    } mdio_state_e;

    // Bit-counter reload value for a field of the given width (counts down to zero).
    function automatic logic [MDIO_CNT_W-1:0] field_last(input int unsigned bits);
        return MDIO_CNT_W'(bits - 1);
    endfunction

endpackage

// File: rtl/eth_mdio_responder_if.sv
// Register-bank port between the MDIO responder (master) and the register bank (slave).
interface eth_mdio_responder_if;

    logic [eth_mdio_pkg::MDIO_ADDR_W-1:0] reg_addr;
    logic                                 reg_rd;
    logic [eth_mdio_pkg::MDIO_DATA_W-1:0] reg_rd_data;
    logic                                 reg_wr;
    logic [eth_mdio_pkg::MDIO_DATA_W-1:0] reg_wr_data;

    modport master (
        output reg_addr,
        output reg_rd,
        output reg_wr,
        output reg_wr_data,
        input  reg_rd_data
    );

    modport slave (
        input  reg_addr,
        input  reg_rd,
        input  reg_wr,
        input  reg_wr_data,
        output reg_rd_data
    );

endinterface

// File: rtl/eth_mdio_sync.sv
// Two-flop synchronizers for MDC/MDIO plus a one-cycle MDC rising-edge pulse.
module eth_mdio_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic mdc_in,
    input  logic mdio_in,
    output logic mdio_s,
    output logic mdc_rise_c
);

    logic mdc_s1;
    logic mdc_s2;
    logic mdc_d;
    logic mdio_s1;

    // Synchronizer chains and the delayed MDC copy used for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdc_s1  <= 1'b0;
            mdc_s2  <= 1'b0;
            mdc_d   <= 1'b0;
            mdio_s1 <= 1'b0;
            mdio_s  <= 1'b0;
        end else begin
            mdc_s1  <= mdc_in;
            mdc_s2  <= mdc_s1;
            mdc_d   <= mdc_s2;
            mdio_s1 <= mdio_in;
            mdio_s  <= mdio_s1;
        end
    end

    assign mdc_rise_c = mdc_s2 & ~mdc_d;

endmodule

// File: rtl/eth_mdio_responder.sv
// PHY-side Clause-22 MDIO responder: decodes frames, strobes the register bank, answers reads.
module eth_mdio_responder #(
    parameter logic [4:0]  PHY_ADDR = 5'd1,
    parameter int unsigned PRE_BITS = 32
) (
    input  logic                 clk_mac,
    input  logic                 rst_n,
    input  logic                 eth_mdc,
    inout  wire                  eth_mdio,
    eth_mdio_responder_if.master reg_bus,
    output logic                 frame_err
);

    import eth_mdio_pkg::*;

    localparam logic [MDIO_PRE_W-1:0] PRE_FULL = MDIO_PRE_W'(PRE_BITS);

    logic                   mdio_s;
    logic                   mdc_rise_c;
    mdio_state_e            state;
    mdio_state_e            state_nxt;
    logic [MDIO_CNT_W-1:0]  bit_cnt;
    logic [MDIO_CNT_W-1:0]  bit_cnt_nxt;
    logic [MDIO_PRE_W-1:0]  pre_cnt;
    logic [MDIO_PRE_W-1:0]  pre_cnt_nxt;
    logic [MDIO_DATA_W-2:0] in_sh;
    logic [MDIO_DATA_W-1:0] field_c;
    logic [MDIO_DATA_W-1:0] tx_sh;
    logic [MDIO_ADDR_W-1:0] regad;
    logic [MDIO_ADDR_W-1:0] reg_addr_q;
    logic [MDIO_DATA_W-1:0] wr_data_q;
    logic                   is_rd;
    logic                   is_wr;
    logic                   match;
    logic                   rd_q;
    logic                   wr_q;
    logic                   rd_stb_c;
    logic                   wr_stb_c;
    logic                   err_c;
    logic                   last_c;
    logic                   drive_c;
    logic                   drive_val_c;
    logic                   mdio_oe;
    logic                   mdio_out;

    eth_mdio_sync u_sync (
        .clk        (clk_mac),
        .rst_n      (rst_n),
        .mdc_in     (eth_mdc),
        .mdio_in    (eth_mdio),
        .mdio_s     (mdio_s),
        .mdc_rise_c (mdc_rise_c)
    );

    // Field value including the bit being sampled on this MDC edge
    assign field_c = {in_sh, mdio_s};
    assign last_c  = (bit_cnt == '0);

    // FSM, bit counter and preamble counter registers
    always_ff @(posedge clk_mac or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_PRE;
            bit_cnt <= '0;
            pre_cnt <= '0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_cnt_nxt;
            pre_cnt <= pre_cnt_nxt;
        end
    end

    // Next-state decode, counter reloads and strobe/error requests
    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        pre_cnt_nxt = pre_cnt;
        rd_stb_c    = 1'b0;
        wr_stb_c    = 1'b0;
        err_c       = 1'b0;
        if (mdc_rise_c) begin
            if (!last_c) begin
                bit_cnt_nxt = bit_cnt - MDIO_CNT_W'(1);
            end
            unique case (state)
                S_PRE: begin
                    if (mdio_s) begin
                        if (pre_cnt != PRE_FULL) begin
                            pre_cnt_nxt = pre_cnt + MDIO_PRE_W'(1);
                        end
                    end else if (pre_cnt == PRE_FULL) begin
                        // This zero is the first ST bit
                        state_nxt   = S_ST;
                        pre_cnt_nxt = '0;
                        bit_cnt_nxt = '0;
                    end else begin
                        pre_cnt_nxt = '0;
                    end
                end
                S_ST: begin
                    if (mdio_s == MDIO_ST[0]) begin
                        state_nxt   = S_OP;
                        bit_cnt_nxt = field_last(MDIO_OP_W);
                    end else begin
                        err_c     = 1'b1;
                        state_nxt = S_PRE;
                    end
                end
                S_OP: begin
                    if (last_c) begin
                        if ((field_c[1:0] == MDIO_OP_RD) || (field_c[1:0] == MDIO_OP_WR)) begin
                            state_nxt   = S_PHYAD;
                            bit_cnt_nxt = field_last(MDIO_ADDR_W);
                        end else begin
                            err_c     = 1'b1;
                            state_nxt = S_PRE;
                        end
                    end
                end
                S_PHYAD: begin
                    if (last_c) begin
                        state_nxt   = S_REGAD;
                        bit_cnt_nxt = field_last(MDIO_ADDR_W);
                    end
                end
                S_REGAD: begin
                    if (last_c) begin
                        state_nxt   = S_TA;
                        bit_cnt_nxt = field_last(MDIO_TA_W);
                        rd_stb_c    = match & is_rd;
                    end
                end
                S_TA: begin
                    if (last_c) begin
                        state_nxt   = S_DATA;
                        bit_cnt_nxt = field_last(MDIO_DATA_W);
                    end
                end
                S_DATA: begin
                    if (last_c) begin
                        state_nxt = S_PRE;
                        wr_stb_c  = match & is_wr;
                    end
                end
                default: state_nxt = S_PRE;
            endcase
        end
    end

    // Capture incoming bits and latch opcode, address match and REGAD at field ends
    always_ff @(posedge clk_mac or negedge rst_n) begin
        if (!rst_n) begin
            in_sh <= '0;
            is_rd <= 1'b0;
            is_wr <= 1'b0;
            match <= 1'b0;
            regad <= '0;
        end else if (mdc_rise_c) begin
            in_sh <= field_c[MDIO_DATA_W-2:0];
            if ((state == S_OP) && last_c) begin
                is_rd <= (field_c[1:0] == MDIO_OP_RD);
                is_wr <= (field_c[1:0] == MDIO_OP_WR);
            end
            if ((state == S_PHYAD) && last_c) begin
                match <= (field_c[MDIO_ADDR_W-1:0] == PHY_ADDR);
            end
            if ((state == S_REGAD) && last_c) begin
                regad <= field_c[MDIO_ADDR_W-1:0];
            end
        end
    end

    // Register-bank strobes, held address/write data and the framing-error pulse
    always_ff @(posedge clk_mac or negedge rst_n) begin
        if (!rst_n) begin
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            frame_err  <= 1'b0;
            reg_addr_q <= '0;
            wr_data_q  <= '0;
        end else begin
            rd_q      <= rd_stb_c;
            wr_q      <= wr_stb_c;
            frame_err <= err_c;
            if (rd_stb_c) begin
                reg_addr_q <= field_c[MDIO_ADDR_W-1:0];
            end
            if (wr_stb_c) begin
                reg_addr_q <= regad;
                wr_data_q  <= field_c;
            end
        end
    end

    // Read data: loaded the cycle after reg_rd, shifted out MSB first during DATA
    always_ff @(posedge clk_mac or negedge rst_n) begin
        if (!rst_n) begin
            tx_sh <= '0;
        end else if (rd_q) begin
            tx_sh <= reg_bus.reg_rd_data;
        end else if (mdc_rise_c && (state == S_DATA)) begin
            tx_sh <= {tx_sh[MDIO_DATA_W-2:0], 1'b0};
        end
    end

    // Drive TA[1] low then the data bits, only for a matching read
    assign drive_c     = match & is_rd & (((state == S_TA) && last_c) || (state == S_DATA));
    assign drive_val_c = (state == S_DATA) ? tx_sh[MDIO_DATA_W-1] : 1'b0;

    // Registered line driver; reset releases the line asynchronously
    always_ff @(posedge clk_mac or negedge rst_n) begin
        if (!rst_n) begin
            mdio_oe  <= 1'b0;
            mdio_out <= 1'b0;
        end else begin
            mdio_oe  <= drive_c;
            mdio_out <= drive_val_c;
        end
    end

    assign eth_mdio = mdio_oe ? mdio_out : 1'bz;

    assign reg_bus.reg_addr    = reg_addr_q;
    assign reg_bus.reg_rd      = rd_q;
    assign reg_bus.reg_wr      = wr_q;
    assign reg_bus.reg_wr_data = wr_data_q;

endmodule

// File: tb/tb_eth_mdio_responder.sv
// Directed bench for eth_mdio_responder: an MDIO initiator task, a fixed-value register bank and pulse monitors.
module tb_eth_mdio_responder;

    import eth_mdio_pkg::*;

    logic        clk_mac = 1'b0;
    logic        rst_n;
    logic        eth_mdc;
    wire         eth_mdio;
    logic        frame_err;
    logic        tb_oe;
    logic        tb_out;
    logic [15:0] bank_data;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          rise_cyc = 0;
    int          n_rd = 0;
    int          n_wr = 0;
    int          n_err = 0;
    int          n_drive = 0;
    int          rd_lat = 0;
    int          wr_lat = 0;
    int          on_lat = 0;
    int          off_lat = 0;
    logic [4:0]  rd_addr = '0;
    logic [4:0]  wr_addr = '0;
    logic [15:0] wr_data_seen = '0;
    logic        oe_prev = 1'b0;
    logic        line_smp;
    logic        ta_bit;
    logic [15:0] rd;
    int          b_rd;
    int          b_wr;
    int          b_err;
    int          b_drv;

    eth_mdio_responder_if rb ();

    assign rb.reg_rd_data = bank_data;
    assign eth_mdio = tb_oe ? tb_out : 1'bz;

    eth_mdio_responder #(
        .PHY_ADDR (5'd1),
        .PRE_BITS (32)
    ) dut (
        .clk_mac   (clk_mac),
        .rst_n     (rst_n),
        .eth_mdc   (eth_mdc),
        .eth_mdio  (eth_mdio),
        .reg_bus   (rb),
        .frame_err (frame_err)
    );

    always #5 clk_mac = ~clk_mac;

    always @(posedge clk_mac) cyc <= cyc + 1;

    // Pulse and line-drive monitors, sampled on the falling clock edge
    always @(negedge clk_mac) begin
        if (rb.reg_rd) begin
            n_rd    = n_rd + 1;
            rd_addr = rb.reg_addr;
            rd_lat  = cyc - rise_cyc;
        end
        if (rb.reg_wr) begin
            n_wr         = n_wr + 1;
            wr_addr      = rb.reg_addr;
            wr_data_seen = rb.reg_wr_data;
            wr_lat       = cyc - rise_cyc;
        end
        if (frame_err) n_err = n_err + 1;
        if (dut.mdio_oe && !oe_prev) on_lat = cyc - rise_cyc;
        if (!dut.mdio_oe && oe_prev) off_lat = cyc - rise_cyc;
        if (dut.mdio_oe) n_drive = n_drive + 1;
        oe_prev = dut.mdio_oe;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One MDC period: 10 clk low with data set up, sample line, 10 clk high
    task automatic mdc_bit(input logic oe, input logic val);
        tb_oe  = oe;
        tb_out = val;
        repeat (10) @(negedge clk_mac);
        line_smp = eth_mdio;
        eth_mdc  = 1'b1;
        rise_cyc = cyc;
        repeat (10) @(negedge clk_mac);
        eth_mdc = 1'b0;
    endtask

    task automatic ones(input int n);
        for (int i = 0; i < n; i++) mdc_bit(1'b1, 1'b1);
    endtask

    // Full Clause-22 frame with 32-bit preamble; abort_bit >= 0 resets the DUT before that data bit
    task automatic mdio_frame(input logic is_read, input logic [4:0] phy, input logic [4:0] ra,
                              input logic [15:0] wdata, input int abort_bit,
                              output logic [15:0] rdata);
        rdata = '0;
        ones(32);
        mdc_bit(1'b1, 1'b0);
        mdc_bit(1'b1, 1'b1);
        mdc_bit(1'b1, is_read);
        mdc_bit(1'b1, !is_read);
        for (int i = 4; i >= 0; i--) mdc_bit(1'b1, phy[i]);
        for (int i = 4; i >= 0; i--) mdc_bit(1'b1, ra[i]);
        if (is_read) begin
            mdc_bit(1'b0, 1'b0);
            mdc_bit(1'b0, 1'b0);
            ta_bit = line_smp;
        end else begin
            mdc_bit(1'b1, 1'b1);
            mdc_bit(1'b1, 1'b0);
        end
        for (int i = 15; i >= 0; i--) begin
            if (i == abort_bit) begin
                chk("drive_before_rst", 32'(dut.mdio_oe), 32'd1);
                rst_n = 1'b0;
                #1;
                chk("rst_release", 32'(dut.mdio_oe), 32'd0);
                chk("rst_reg_addr", 32'(rb.reg_addr), 32'd0);
                chk("rst_reg_rd", 32'(rb.reg_rd), 32'd0);
                chk("rst_reg_wr", 32'(rb.reg_wr), 32'd0);
                chk("rst_wr_data", 32'(rb.reg_wr_data), 32'd0);
                chk("rst_frame_err", 32'(frame_err), 32'd0);
                chk("rst_state", 32'(dut.state), 32'(S_PRE));
                repeat (4) @(negedge clk_mac);
                rst_n  = 1'b1;
                tb_oe  = 1'b1;
                tb_out = 1'b1;
                repeat (4) @(negedge clk_mac);
                return;
            end
            mdc_bit(!is_read, wdata[i]);
            rdata[i] = line_smp;
        end
    endtask

    initial begin
        eth_mdc   = 1'b0;
        tb_oe     = 1'b1;
        tb_out    = 1'b1;
        rst_n     = 1'b0;
        bank_data = '0;
        ta_bit    = 1'b1;
        line_smp  = 1'b0;
        repeat (5) @(negedge clk_mac);

        chk("reset_reg_addr", 32'(rb.reg_addr), 32'd0);
        chk("reset_reg_rd", 32'(rb.reg_rd), 32'd0);
        chk("reset_reg_wr", 32'(rb.reg_wr), 32'd0);
        chk("reset_wr_data", 32'(rb.reg_wr_data), 32'd0);
        chk("reset_frame_err", 32'(frame_err), 32'd0);
        chk("reset_line_oe", 32'(dut.mdio_oe), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk_mac);

        // Matching read, PHYAD 1 / REGAD 2
        bank_data = 16'h7C0F;
        b_rd = n_rd; b_err = n_err;
        mdio_frame(1'b1, 5'd1, 5'd2, 16'h0000, -1, rd);
        chk("rd1_count", 32'(n_rd - b_rd), 32'd1);
        chk("rd1_addr", 32'(rd_addr), 32'd2);
        chk("rd1_strobe_lat", 32'(rd_lat), 32'd3);
        chk("rd1_ta_bit", 32'(ta_bit), 32'd0);
        chk("rd1_data", 32'(rd), 32'h7C0F);
        chk("rd1_drive_lat", 32'(on_lat), 32'd4);
        chk("rd1_release_lat", 32'(off_lat), 32'd4);
        chk("rd1_released", 32'(dut.mdio_oe), 32'd0);
        chk("rd1_no_err", 32'(n_err - b_err), 32'd0);

        // Matching write, REGAD 0 / 16'h3100
        b_wr = n_wr; b_rd = n_rd; b_drv = n_drive;
        mdio_frame(1'b0, 5'd1, 5'd0, 16'h3100, -1, rd);
        chk("wr1_count", 32'(n_wr - b_wr), 32'd1);
        chk("wr1_addr", 32'(wr_addr), 32'd0);
        chk("wr1_data", 32'(wr_data_seen), 32'h3100);
        chk("wr1_strobe_lat", 32'(wr_lat), 32'd3);
        chk("wr1_no_rd", 32'(n_rd - b_rd), 32'd0);
        chk("wr1_no_drive", 32'(n_drive - b_drv), 32'd0);
        chk("wr1_held_data", 32'(rb.reg_wr_data), 32'h3100);

        // Frames to PHYAD 3 are ignored, then PHYAD 1 is served
        b_wr = n_wr; b_rd = n_rd; b_drv = n_drive;
        bank_data = 16'hFFFF;
        mdio_frame(1'b1, 5'd3, 5'd2, 16'h0000, -1, rd);
        mdio_frame(1'b0, 5'd3, 5'd7, 16'hABCD, -1, rd);
        chk("phy3_no_rd", 32'(n_rd - b_rd), 32'd0);
        chk("phy3_no_wr", 32'(n_wr - b_wr), 32'd0);
        chk("phy3_no_drive", 32'(n_drive - b_drv), 32'd0);
        chk("phy3_held_data", 32'(rb.reg_wr_data), 32'h3100);
        chk("phy3_held_addr", 32'(rb.reg_addr), 32'd0);
        bank_data = 16'hA5C3;
        mdio_frame(1'b1, 5'd1, 5'd17, 16'h0000, -1, rd);
        chk("phy1_after_rd_count", 32'(n_rd - b_rd), 32'd1);
        chk("phy1_after_addr", 32'(rd_addr), 32'd17);
        chk("phy1_after_data", 32'(rd), 32'hA5C3);

        // Short preamble broken by a zero: silently restarted
        b_err = n_err; b_rd = n_rd;
        ones(20);
        mdc_bit(1'b1, 1'b0);
        chk("short_pre_no_err", 32'(n_err - b_err), 32'd0);
        chk("short_pre_state", 32'(dut.state), 32'(S_PRE));
        bank_data = 16'h1234;
        mdio_frame(1'b1, 5'd1, 5'd5, 16'h0000, -1, rd);
        chk("short_pre_rd_count", 32'(n_rd - b_rd), 32'd1);
        chk("short_pre_addr", 32'(rd_addr), 32'd5);
        chk("short_pre_data", 32'(rd), 32'h1234);
        chk("short_pre_no_err2", 32'(n_err - b_err), 32'd0);

        // Bad framing: ST=00, then OP=11
        b_err = n_err; b_rd = n_rd; b_wr = n_wr;
        ones(32);
        mdc_bit(1'b1, 1'b0);
        mdc_bit(1'b1, 1'b0);
        chk("bad_st_err", 32'(n_err - b_err), 32'd1);
        chk("bad_st_state", 32'(dut.state), 32'(S_PRE));
        ones(32);
        mdc_bit(1'b1, 1'b0);
        mdc_bit(1'b1, 1'b1);
        mdc_bit(1'b1, 1'b1);
        mdc_bit(1'b1, 1'b1);
        chk("bad_op_err", 32'(n_err - b_err), 32'd2);
        chk("bad_op_state", 32'(dut.state), 32'(S_PRE));
        chk("bad_no_rd", 32'(n_rd - b_rd), 32'd0);
        chk("bad_no_wr", 32'(n_wr - b_wr), 32'd0);

        // Reset during the read data phase, then a clean read
        b_wr = n_wr;
        bank_data = 16'hBEEF;
        mdio_frame(1'b1, 5'd1, 5'd3, 16'h0000, 8, rd);
        chk("abort_no_wr", 32'(n_wr - b_wr), 32'd0);
        b_rd = n_rd;
        bank_data = 16'h0F0F;
        mdio_frame(1'b1, 5'd1, 5'd4, 16'h0000, -1, rd);
        chk("post_rst_rd_count", 32'(n_rd - b_rd), 32'd1);
        chk("post_rst_addr", 32'(rd_addr), 32'd4);
        chk("post_rst_data", 32'(rd), 32'h0F0F);
        chk("post_rst_released", 32'(dut.mdio_oe), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
